// File: rtl/multicycle_control_fsm.sv
// Control state machine for the multi-cycle RV32I core.
// Sequences fetch / decode / execute / memory / writeback from the opcode,
// stalls on mem_ready, halts on ECALL or memory timeout, counts retires.
// Optional build macro: ILLEGAL_TRAP_EN -- adds sticky output illegal_inst
// and traps unknown opcodes into HALT instead of treating them as NOPs.
module multicycle_control_fsm #(
    parameter int MEM_WAIT_LIMIT = 0,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 mem_ready,
    input  logic                 bcond,
    input  logic                 halt_req,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic                 IorD,
    output logic                 IRWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [1:0]           MemtoReg,
    output logic                 RegWrite,
    output logic                 PCWrite,
    output logic [1:0]           PCSource,
    output logic                 is_halted,
    output logic                 mem_timeout,
`ifdef ILLEGAL_TRAP_EN
    output logic                 illegal_inst,
`endif
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EX_R   = 4'd2,
        EX_I   = 4'd3,
        WB_ALU = 4'd4,
        ADDR   = 4'd5,
        MEM_LD = 4'd6,
        WB_LD  = 4'd7,
        MEM_ST = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        JALR   = 4'd11,
        HALT   = 4'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Count value at which one more idle cycle reaches the wait limit.
    localparam logic [31:0] WAIT_LAST = 32'(MEM_WAIT_LIMIT - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] wait_cnt;
    logic        wait_expired;
    logic        mem_wait_state;
    logic        retire;
    logic        timeout_hit;
    logic        illegal_hit;

    assign is_halted      = (state == HALT);
    assign mem_wait_state = (state == FETCH) || (state == MEM_LD) || (state == MEM_ST);
    assign wait_expired   = (MEM_WAIT_LIMIT > 0) && (wait_cnt == WAIT_LAST);

    // Next-state selection and combinational control decode per state.
    always_comb begin
        next_state  = state;
        retire      = 1'b0;
        timeout_hit = 1'b0;
        illegal_hit = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 2'b00;
        RegWrite    = 1'b0;
        PCWrite     = 1'b0;
        PCSource    = 2'b00;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite    = ~reset;
                    next_state = DECODE;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = HALT;
                end
            end
            DECODE: begin
                ALUSrcA = 1'b0;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b00;
                case (opcode)
                    OP_R:      next_state = EX_R;
                    OP_I:      next_state = EX_I;
                    OP_LOAD:   next_state = ADDR;
                    OP_STORE:  next_state = ADDR;
                    OP_BRANCH: next_state = BRANCH;
                    OP_JAL:    next_state = JAL;
                    OP_JALR:   next_state = JALR;
                    OP_SYSTEM: begin
                        if (halt_req) begin
                            next_state = HALT;
                        end else begin
                            PCWrite    = 1'b1;
                            PCSource   = 2'b10;
                            retire     = 1'b1;
                            next_state = FETCH;
                        end
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        illegal_hit = 1'b1;
                        next_state  = HALT;
`else
                        PCWrite    = 1'b1;
                        PCSource   = 2'b10;
                        retire     = 1'b1;
                        next_state = FETCH;
`endif
                    end
                endcase
            end
            EX_R: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b00;
                ALUOp      = 2'b10;
                next_state = WB_ALU;
            end
            EX_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 2'b11;
                next_state = WB_ALU;
            end
            WB_ALU: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b00;
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                retire     = 1'b1;
                next_state = FETCH;
            end
            ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 2'b00;
                next_state = (opcode == OP_LOAD) ? MEM_LD : MEM_ST;
            end
            MEM_LD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    next_state = WB_LD;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = HALT;
                end
            end
            WB_LD: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEM_ST: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    retire     = 1'b1;
                    next_state = FETCH;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = HALT;
                end
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b00;
                ALUOp      = 2'b01;
                PCWrite    = 1'b1;
                PCSource   = bcond ? 2'b01 : 2'b10;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b10;
                PCWrite    = 1'b1;
                PCSource   = 2'b01;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JALR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 2'b00;
                RegWrite   = 1'b1;
                MemtoReg   = 2'b10;
                PCWrite    = 1'b1;
                PCSource   = 2'b00;
                retire     = 1'b1;
                next_state = FETCH;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    // State register; reset returns to FETCH without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Memory wait counter: cleared on any state change, counts idle cycles in wait states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 32'd0;
        end else if (next_state != state) begin
            wait_cnt <= 32'd0;
        end else if (mem_wait_state && !mem_ready) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    // Retired-instruction counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (retire) begin
                instret <= instret + 1'b1;
            end
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky flag recording that the halt came from an unknown opcode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_inst <= 1'b0;
        end else if (illegal_hit) begin
            illegal_inst <= 1'b1;
        end
    end
`else
    // Without the trap build the illegal-opcode indication has no consumer.
    logic unused_illegal;
    assign unused_illegal = illegal_hit;
`endif

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised control state machine for the multi-cycle RV32I core.
- Decodes the 7-bit opcode and sequences fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake and resolves branches from a datapath condition flag.
- Halts on ECALL (when the halt request is asserted) and on memory timeout; counts retired instructions.

Parameters:
MEM_WAIT_LIMIT, 0, max cycles to wait for mem_ready per access; 0 = unlimited
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  7  IR[6:0]
mem_ready  in  1  memory completes current access this cycle
bcond  in  1  datapath branch condition for current compare
halt_req  in  1  ECALL halts (datapath: x17==10)
ALUSrcA  out  1  0=PC, 1=rs1
ALUSrcB  out  2  00=rs2, 01=const 4, 10=imm
ALUOp  out  2  00=add, 01=branch compare, 10=R-type funct, 11=I-type funct
IorD  out  1  0=PC address, 1=ALUOut address
IRWrite  out  1  load IR (and datapath PC+4 register)
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC+4 register
RegWrite  out  1  register file write
PCWrite  out  1  PC load
PCSource  out  2  00=ALU result, 01=ALUOut, 10=PC+4 register
is_halted  out  1  sticky halt flag
mem_timeout  out  1  sticky; halt caused by timeout
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset: the clock and reset ports are named clk and reset. One clock; reset is asynchronous and active-high. It forces state=FETCH, the wait counter, instret, is_halted and mem_timeout to 0.
- Control outputs are combinational from state plus mem_ready/bcond/halt_req. Any output not listed for a state is 0. During reset, outputs are the FETCH values: MemRead=1, IorD=0, all others 0.
- State machine (4-bit state):
  - FETCH: MemRead. While mem_ready=1, also assert IRWrite and go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00, so ALUOut=PC+imm next cycle. Dispatch on opcode:
    - 0110011 -> EX_R
    - 0010011 -> EX_I
    - 0000011 or 0100011 -> ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 1110011 with halt_req -> HALT
    - 1110011 without halt_req -> PCWrite, PCSource=10, retire, FETCH
  - EX_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_ALU.
  - EX_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> WB_ALU.
  - WB_ALU: RegWrite, MemtoReg=00, PCWrite, PCSource=10; retire -> FETCH.
  - ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_LD if opcode is load, else MEM_ST.
  - MEM_LD: IorD=1, MemRead. Hold until mem_ready -> WB_LD.
  - WB_LD: RegWrite, MemtoReg=01, PCWrite, PCSource=10; retire -> FETCH.
  - MEM_ST: IorD=1, MemWrite. On the mem_ready cycle also PCWrite, PCSource=10; retire -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWrite. PCSource=01 if bcond, else 10. Retire -> FETCH.
  - JAL: RegWrite, MemtoReg=10, PCWrite, PCSource=01; retire -> FETCH.
  - JALR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, RegWrite, MemtoReg=10, PCWrite, PCSource=00 (datapath clears bit 0); retire -> FETCH.
  - HALT: all controls 0, is_halted=1. Sticky until reset; ignores all inputs.
- Memory wait: the counter clears on entry to FETCH, MEM_LD and MEM_ST, and increments each cycle mem_ready=0 in those states.
  - If MEM_WAIT_LIMIT>0 and the count reaches MEM_WAIT_LIMIT with mem_ready still 0: go to HALT and set mem_timeout=1.
  - mem_ready in the same cycle as the limit wins; the access completes.
- instret increments by 1 on each retire edge, wrapping at 2^INSTRET_W. The halting ECALL does not retire.
- Unknown opcode in DECODE: behaviour is set by ILLEGAL_TRAP_EN.
- Latency with mem_ready tied high:
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch, JAL, JALR: 3 cycles
- Reset asserted mid-access: immediate return to FETCH, no write strobes after reset asserts.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_inst (1 bit, sticky, reset 0).
  - An unknown opcode in DECODE goes to HALT with illegal_inst=1 and no retire.
- Undefined:
  - An unknown opcode is a NOP: PCWrite, PCSource=10, retire, FETCH.
  - The port is absent.

Test Plan:
- R-type add (0110011), mem_ready=1 -> states FETCH, DECODE, EX_R, WB_ALU; RegWrite=1 only in cycle 4; instret 0->1.
- Load (0000011) with mem_ready low 3 cycles in MEM_LD -> MemRead, IorD=1 held 4 cycles; then WB_LD MemtoReg=01; total 8 cycles.
- Branch (1100011) with bcond=1, then again with bcond=0 -> PCSource=01, then 10; PCWrite=1 in the BRANCH cycle both times; instret +2.
- MEM_WAIT_LIMIT=4, mem_ready stuck 0 in FETCH -> HALT after 4 cycles; is_halted=1, mem_timeout=1; later mem_ready is ignored.
- ECALL with halt_req=1 -> HALT, instret unchanged. ECALL with halt_req=0 -> PC+4, instret+1.
- reset pulsed during MEM_ST with MemWrite=1 -> MemWrite drops asynchronously; state FETCH, instret=0. Also opcode 0000000 with and without ILLEGAL_TRAP_EN -> HALT with illegal_inst=1 / NOP retire.
